modsq_carry_resolve: RTL

- Sits directly downstream of the modular-squaring wrapper, in the `clk` domain.
- Captures one redundant-form squaring result: NUM_ELEMENTS coefficients, each BIT_LEN bits wide, packed in 2*WORD_LEN-bit slots.
- Resolves inter-coefficient carries sequentially, ELEMS_PER_CYCLE coefficients per cycle.
- Presents the canonical integer sum(c_j * 2^(WORD_LEN*j)) on a valid/ready output for the loop controller and host readback.

---
 rtl/modsq_pkg.sv | 27 ++
 rtl/modsq_carry_resolve_carry_chunk_adder.sv | 30 +++
 rtl/modsq_carry_resolve.sv | 127 ++++++++++++
 3 files changed

// File: rtl/modsq_pkg.sv
// Shared constants and types for the modular-squaring carry-resolve stage.
// Coefficients are redundant-form (BIT_LEN bits) at a WORD_LEN-bit radix.
package modsq_pkg;

    localparam int MOD_LEN         = 1024;
    localparam int WORD_LEN        = 16;
    localparam int BIT_LEN         = 17;
    localparam int NUM_ELEMENTS    = MOD_LEN / WORD_LEN + 1;
    localparam int ELEMS_PER_CYCLE = 8;
    localparam int NUM_CHUNKS      = (NUM_ELEMENTS + ELEMS_PER_CYCLE - 1) / ELEMS_PER_CYCLE;
    localparam int NUM_PADDED      = NUM_CHUNKS * ELEMS_PER_CYCLE;
    localparam int RES_LEN         = NUM_ELEMENTS * WORD_LEN + 2;
    localparam int CARRY_LEN       = BIT_LEN - WORD_LEN + 1;
    localparam int SLOT_LEN        = 2 * WORD_LEN;
    localparam int CHUNK_CNT_W     = $clog2(NUM_CHUNKS);

    typedef logic [BIT_LEN-1:0]   coef_t;
    typedef logic [WORD_LEN-1:0]  word_t;
    typedef logic [CARRY_LEN-1:0] carry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } resolve_state_e;

endpackage

// File: rtl/modsq_carry_resolve_carry_chunk_adder.sv
// Combinational ripple of one chunk of coefficients: each coefficient plus the
// incoming carry yields one radix word and the carry for the next coefficient.
module carry_chunk_adder
    import modsq_pkg::*;
(
    input  logic [ELEMS_PER_CYCLE*BIT_LEN-1:0]  coefs,
    input  carry_t                              carry_in,
    output logic [ELEMS_PER_CYCLE*WORD_LEN-1:0] words,
    output carry_t                              carry_out
);

    localparam int SUM_W = BIT_LEN + 1;

    logic [SUM_W-1:0] sum_s;
    carry_t           carry_s;

    // Ripple the carry through every coefficient of the chunk.
    always_comb begin
        sum_s   = '0;
        carry_s = carry_in;
        words   = '0;
        for (int i = 0; i < ELEMS_PER_CYCLE; i++) begin
            sum_s = {1'b0, coefs[i*BIT_LEN +: BIT_LEN]} + SUM_W'(carry_s);
            words[i*WORD_LEN +: WORD_LEN] = sum_s[WORD_LEN-1:0];
            carry_s = sum_s[SUM_W-1:WORD_LEN];
        end
        carry_out = carry_s;
    end

endmodule

// File: rtl/modsq_carry_resolve.sv
// Captures one redundant-form squaring result and resolves it into a canonical
// integer, one chunk of ELEMS_PER_CYCLE coefficients per clock.
module modsq_carry_resolve
    import modsq_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_ELEMENTS*SLOT_LEN-1:0]   in_coeffs,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [RES_LEN-1:0]                 out_value,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               overrun
);

    localparam int COEF_W       = NUM_PADDED * BIT_LEN;
    localparam int CHUNK_COEF_W = ELEMS_PER_CYCLE * BIT_LEN;
    localparam int CHUNK_WORD_W = ELEMS_PER_CYCLE * WORD_LEN;
    localparam int ACC_W        = (NUM_CHUNKS - 1) * CHUNK_WORD_W;
    localparam logic [CHUNK_CNT_W-1:0] LAST_CHUNK = CHUNK_CNT_W'(NUM_CHUNKS - 1);

    resolve_state_e             state_r, state_s;
    logic [COEF_W-1:0]          coef_r, coef_load_s;
    logic [ACC_W-1:0]           acc_r;
    logic [CHUNK_CNT_W-1:0]     chunk_r;
    carry_t                     carry_r, carry_s;
    logic [CHUNK_WORD_W-1:0]    words_s;
    logic [RES_LEN-1:0]         final_s;
    logic [RES_LEN-1:0]         out_value_r;
    logic                       in_ready_r, out_valid_r, busy_r, overrun_r;

    // Keep the low BIT_LEN bits of each slot; padding coefficients are zero.
    always_comb begin
        coef_load_s = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            coef_load_s[j*BIT_LEN +: BIT_LEN] = in_coeffs[j*SLOT_LEN +: BIT_LEN];
        end
    end

    carry_chunk_adder u_adder (
        .coefs     (coef_r[CHUNK_COEF_W-1:0]),
        .carry_in  (carry_r),
        .words     (words_s),
        .carry_out (carry_s)
    );

    // The carry out of the last real coefficient lands in the first padding
    // word, whose low bits are exactly the top result bits; with no padding
    // it is the final chunk carry that supplies them instead.
    always_comb begin
        final_s = RES_LEN'({words_s, acc_r}) | {carry_s, {(RES_LEN-CARRY_LEN){1'b0}}};
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (chunk_r == LAST_CHUNK) state_s = DONE;
                else                       state_s = RUN;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            coef_r      <= '0;
            acc_r       <= '0;
            chunk_r     <= '0;
            carry_r     <= '0;
            out_value_r <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
            if (in_valid && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        coef_r  <= coef_load_s;
                        acc_r   <= '0;
                        carry_r <= '0;
                        chunk_r <= '0;
                    end
                end
                RUN: begin
                    coef_r  <= {{CHUNK_COEF_W{1'b0}}, coef_r[COEF_W-1:CHUNK_COEF_W]};
                    acc_r   <= {words_s, acc_r[ACC_W-1:CHUNK_WORD_W]};
                    carry_r <= carry_s;
                    chunk_r <= chunk_r + CHUNK_CNT_W'(1);
                    if (chunk_r == LAST_CHUNK) begin
                        out_value_r <= final_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign out_value = out_value_r;

endmodule
